tx_response_formatter: RTL and testbench

- Sits between the register file read port and UART_TX, in the response path of the UART command parser / register file design.
- Captures each read-data byte into a small FIFO.
- Converts each byte to a two-character uppercase ASCII hex string, optionally terminated by CR LF.
- Drives UART_TX one character at a time via a start/busy handshake, so back-to-back reads are never lost while the transmitter is busy.

---
 rtl/tx_response_formatter_pkg.sv | 34 +++
 rtl/tx_response_formatter_byte_fifo.sv | 83 ++++++++
 rtl/tx_response_formatter.sv | 155 +++++++++++++++
 tb/tb_tx_response_formatter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_response_formatter_pkg.sv
// -----------------------------------------------------------------------------
// tx_response_formatter_pkg
// Shared definitions for the register-read response path:
//   - ASCII constants used when rendering a byte as hex text
//   - FSM state encoding of the formatter
//   - nibble_to_ascii: 4-bit value -> uppercase ASCII hex character
// -----------------------------------------------------------------------------
package tx_response_formatter_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_SEND    = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_WAIT_LO = 3'd4
   } fsm_state_t;

   // 0..9 map onto '0'..'9', 10..15 onto 'A'..'F' (uppercase only).
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
      logic [7:0] result;
      if (nibble < 4'd10) begin
         result = ASCII_0 + {4'd0, nibble};
      end else begin
         result = ASCII_A + {4'd0, nibble - 4'd10};
      end
      return result;
   endfunction

endpackage

// File: rtl/tx_response_formatter_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Small synchronous byte FIFO holding register read data until the formatter
// is ready to render it.
//
// Ports:
//   clk        in   system clock (rising edge)
//   reset      in   asynchronous active-high reset; empties the FIFO
//   push       in   write request for push_data
//   push_data  in   byte to enqueue
//   pop        in   remove the head entry
//   head_data  out  entry at the read pointer (valid while !empty)
//   count      out  number of stored entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//
// A push while full is accepted only if a pop happens in the same cycle; the
// slot being freed is the one written, and head_data still shows the old
// value during that cycle because the array read is combinational.
// -----------------------------------------------------------------------------
module byte_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    head_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   COUNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE    = 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          do_push;
   logic          do_pop;

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == FULL_COUNT);
   assign count     = count_reg;
   assign head_data = mem[rd_ptr_reg];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage carries no reset: contents are only observable through count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointer width equals log2(DEPTH), so wrap-around is natural overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + COUNT_ONE;
            2'b01:   count_reg <= count_reg - COUNT_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/tx_response_formatter.sv
// -----------------------------------------------------------------------------
// tx_response_formatter
// Response path between the register file read port and UART_TX. Each read
// byte is queued, rendered as two uppercase ASCII hex characters (optionally
// followed by CR LF) and handed to UART_TX one character at a time using the
// tx_start / tx_busy handshake.
//
// Ports:
//   clk         in   system clock (rising edge)
//   reset       in   asynchronous active-high reset; clears all state
//   rd_valid    in   one-cycle pulse, rd_data is valid
//   rd_data     in   read byte to report
//   tx_busy     in   UART_TX busy flag
//   tx_start    out  one-cycle pulse asking UART_TX to send tx_data
//   tx_data     out  ASCII character, held from one tx_start to the next
//   fifo_count  out  bytes waiting in the FIFO (0..DEPTH)
//   overflow    out  sticky: a read byte was dropped on a full FIFO
//   idle        out  FIFO empty and formatter in IDLE
// -----------------------------------------------------------------------------
module tx_response_formatter
   import tx_response_formatter_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int AW          = 2,
   parameter int APPEND_CRLF = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rd_valid,
   input  logic [7:0]    rd_data,
   input  logic          tx_busy,
   output logic          tx_start,
   output logic [7:0]    tx_data,
   output logic [AW:0]   fifo_count,
   output logic          overflow,
   output logic          idle
);

   // Index of the final character of one rendered byte.
   localparam logic [1:0] LAST_IDX = (APPEND_CRLF != 0) ? 2'd3 : 2'd1;

   fsm_state_t  state_reg;
   logic [7:0]  cur_byte_reg;
   logic [1:0]  char_idx_reg;
   logic        tx_start_reg;
   logic [7:0]  tx_data_reg;
   logic        overflow_reg;

   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_head;
   logic [AW:0] fifo_count_w;
   logic [7:0]  cur_char;

   // The head byte leaves the FIFO only during the LOAD cycle.
   assign fifo_pop = (state_reg == ST_LOAD);

   byte_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rd_valid),
      .push_data (rd_data),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .count     (fifo_count_w),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Character selected by char_idx for the byte being formatted.
   always_comb begin
      cur_char = 8'h00;
      case (char_idx_reg)
         2'd0:    cur_char = nibble_to_ascii(cur_byte_reg[7:4]);
         2'd1:    cur_char = nibble_to_ascii(cur_byte_reg[3:0]);
         2'd2:    cur_char = ASCII_CR;
         default: cur_char = ASCII_LF;
      endcase
   end

   // A drop happens only when full and the FSM is not freeing a slot now.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_reg <= 1'b0;
      end else if (rd_valid && fifo_full && !fifo_pop) begin
         overflow_reg <= 1'b1;
      end
   end

   // Formatter FSM. tx_start is a registered pulse: it defaults low every
   // cycle and is raised only on the SEND -> WAIT_HI transition, so it can
   // never last longer than one cycle. WAIT_HI guards against UART_TX taking
   // a cycle to raise busy after seeing tx_start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         cur_byte_reg <= 8'h00;
         char_idx_reg <= 2'd0;
         tx_start_reg <= 1'b0;
         tx_data_reg  <= 8'h00;
      end else begin
         tx_start_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state_reg <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               cur_byte_reg <= fifo_head;
               char_idx_reg <= 2'd0;
               state_reg    <= ST_SEND;
            end
            ST_SEND: begin
               if (!tx_busy) begin
                  tx_start_reg <= 1'b1;
                  tx_data_reg  <= cur_char;
                  state_reg    <= ST_WAIT_HI;
               end
            end
            ST_WAIT_HI: begin
               if (tx_busy) begin
                  state_reg <= ST_WAIT_LO;
               end
            end
            ST_WAIT_LO: begin
               if (!tx_busy) begin
                  if (char_idx_reg != LAST_IDX) begin
                     char_idx_reg <= char_idx_reg + 2'd1;
                     state_reg    <= ST_SEND;
                  end else if (!fifo_empty) begin
                     state_reg <= ST_LOAD;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_start   = tx_start_reg;
   assign tx_data    = tx_data_reg;
   assign fifo_count = fifo_count_w;
   assign overflow   = overflow_reg;
   assign idle       = (state_reg == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_tx_response_formatter.sv
// -----------------------------------------------------------------------------
// tb_tx_response_formatter
// Two formatter instances: dut_a renders hex + CR LF, dut_b hex only. Each
// has a small UART_TX model (busy for BUSY_CYCLES after each tx_start) that
// dut_a's stimulus can override to drive tx_busy by hand. Expected characters
// are queued when a read byte is driven and compared on every tx_start.
// -----------------------------------------------------------------------------
module tb_tx_response_formatter;

   localparam int BUSY_CYCLES = 10;
   localparam int TIMEOUT     = 3000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // dut_a: APPEND_CRLF = 1
   logic       rd_valid_a;
   logic [7:0] rd_data_a;
   logic       tx_busy_a;
   logic       tx_start_a;
   logic [7:0] tx_data_a;
   logic [2:0] fifo_count_a;
   logic       overflow_a;
   logic       idle_a;
   logic       manual_a;
   logic       manual_busy_a;
   int         busy_cnt_a;

   // dut_b: APPEND_CRLF = 0
   logic       rd_valid_b;
   logic [7:0] rd_data_b;
   logic       tx_busy_b;
   logic       tx_start_b;
   logic [7:0] tx_data_b;
   logic [2:0] fifo_count_b;
   logic       overflow_b;
   logic       idle_b;
   int         busy_cnt_b;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   int         pulses_a;
   int         pulses_b;
   int         n_pass;
   int         n_fail;
   int         n_total;

   tx_response_formatter #(.DEPTH(4), .AW(2), .APPEND_CRLF(1)) dut_a (
      .clk        (clk),
      .reset      (rst),
      .rd_valid   (rd_valid_a),
      .rd_data    (rd_data_a),
      .tx_busy    (tx_busy_a),
      .tx_start   (tx_start_a),
      .tx_data    (tx_data_a),
      .fifo_count (fifo_count_a),
      .overflow   (overflow_a),
      .idle       (idle_a)
   );

   tx_response_formatter #(.DEPTH(4), .AW(2), .APPEND_CRLF(0)) dut_b (
      .clk        (clk),
      .reset      (rst),
      .rd_valid   (rd_valid_b),
      .rd_data    (rd_data_b),
      .tx_busy    (tx_busy_b),
      .tx_start   (tx_start_b),
      .tx_data    (tx_data_b),
      .fifo_count (fifo_count_b),
      .overflow   (overflow_b),
      .idle       (idle_b)
   );

   // UART_TX models
   always @(posedge clk or posedge rst) begin
      if (rst) busy_cnt_a <= 0;
      else if (tx_start_a) busy_cnt_a <= BUSY_CYCLES;
      else if (busy_cnt_a != 0) busy_cnt_a <= busy_cnt_a - 1;
   end
   always @(posedge clk or posedge rst) begin
      if (rst) busy_cnt_b <= 0;
      else if (tx_start_b) busy_cnt_b <= BUSY_CYCLES;
      else if (busy_cnt_b != 0) busy_cnt_b <= busy_cnt_b - 1;
   end
   assign tx_busy_a = manual_a ? manual_busy_a : (busy_cnt_a != 0);
   assign tx_busy_b = (busy_cnt_b != 0);

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_total++;
      assert (observed === expected) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      logic [7:0] v;
      v = {4'd0, n};
      return (v < 8'd10) ? (8'h30 + v) : (8'h37 + v);
   endfunction

   task automatic push_exp_a(input logic [7:0] d);
      exp_a.push_back(hex_char(d[7:4]));
      exp_a.push_back(hex_char(d[3:0]));
      exp_a.push_back(8'h0D);
      exp_a.push_back(8'h0A);
   endtask

   // Called at a negedge; returns at the negedge after the push edge.
   task automatic send_a(input logic [7:0] d);
      rd_valid_a = 1'b1;
      rd_data_a  = d;
      push_exp_a(d);
      @(negedge clk);
      rd_valid_a = 1'b0;
   endtask

   task automatic drain_a(input string tag);
      int n = 0;
      while ((exp_a.size() != 0 || !idle_a) && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check(tag, (n < TIMEOUT), 1);
   endtask

   task automatic wait_pulses_a(input int target, input string tag);
      int n = 0;
      while (pulses_a < target && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check(tag, (n < TIMEOUT), 1);
   endtask

   // Character monitor / scoreboard, sampled on the falling edge.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!rst && tx_start_a) begin
            pulses_a++;
            if (exp_a.size() == 0) begin
               check("a_extra_tx_start", 0, 1);
            end else begin
               e = exp_a.pop_front();
               check("a_tx_data", {24'd0, tx_data_a}, {24'd0, e});
            end
         end
         if (!rst && tx_start_b) begin
            pulses_b++;
            if (exp_b.size() == 0) begin
               check("b_extra_tx_start", 0, 1);
            end else begin
               e = exp_b.pop_front();
               check("b_tx_data", {24'd0, tx_data_b}, {24'd0, e});
            end
         end
      end
   end

   initial begin
      int base;
      int lat;
      int n;
      n_pass = 0; n_fail = 0; n_total = 0;
      pulses_a = 0; pulses_b = 0;
      rst = 1'b1;
      rd_valid_a = 1'b0; rd_data_a = 8'h00; manual_a = 1'b0; manual_busy_a = 1'b0;
      rd_valid_b = 1'b0; rd_data_b = 8'h00;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_tx_start", tx_start_a, 0);
      check("rst_tx_data", tx_data_a, 8'h00);
      check("rst_fifo_count", fifo_count_a, 0);
      check("rst_overflow", overflow_a, 0);
      check("rst_idle", idle_a, 1);
      check("rst_idle_b", idle_b, 1);
      rst = 1'b0;
      @(negedge clk);

      // APPEND_CRLF=0 instance: 0x5E -> '5','E' only
      base = pulses_b;
      rd_valid_b = 1'b1; rd_data_b = 8'h5E;
      exp_b.push_back(8'h35); exp_b.push_back(8'h45);
      @(negedge clk);
      rd_valid_b = 1'b0;
      n = 0;
      while ((exp_b.size() != 0 || !idle_b) && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check("b_drain", (n < TIMEOUT), 1);
      repeat (20) @(negedge clk);
      check("b_pulse_count", pulses_b - base, 2);
      check("b_idle", idle_b, 1);

      // Single byte 0xA5, first-character latency
      base = pulses_a;
      send_a(8'hA5);
      lat = 0;
      while (!tx_start_a && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency_first_start", lat, 3);
      drain_a("drain_a5");
      repeat (20) @(negedge clk);
      check("a5_pulse_count", pulses_a - base, 4);
      check("a5_idle", idle_a, 1);

      // Digits and all-ones, back to back
      base = pulses_a;
      send_a(8'h09);
      send_a(8'hFF);
      drain_a("drain_09_ff");
      check("09_ff_pulse_count", pulses_a - base, 8);

      // Burst with UART held busy: 0x01 is taken into the formatter,
      // 0x02..0x05 fill the FIFO, 0x06 is dropped.
      manual_a = 1'b1; manual_busy_a = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         rd_valid_a = 1'b1;
         rd_data_a  = i[7:0];
         if (i <= 5) push_exp_a(i[7:0]);
         @(negedge clk);
      end
      rd_valid_a = 1'b0;
      @(negedge clk);
      check("burst_fifo_count", fifo_count_a, 4);
      check("burst_overflow", overflow_a, 1);
      manual_a = 1'b0;
      drain_a("drain_burst");
      check("burst_overflow_sticky", overflow_a, 1);
      check("burst_fifo_empty", fifo_count_a, 0);

      // Reset in the middle of 0xC3 after its second character
      base = pulses_a;
      rd_valid_a = 1'b1; rd_data_a = 8'hC3;
      exp_a.push_back(8'h43); exp_a.push_back(8'h33);
      @(negedge clk);
      rd_valid_a = 1'b0;
      wait_pulses_a(base + 2, "wait_c3_second");
      rst = 1'b1;
      #1;
      check("midrst_tx_start", tx_start_a, 0);
      check("midrst_fifo_count", fifo_count_a, 0);
      check("midrst_idle", idle_a, 1);
      check("midrst_overflow", overflow_a, 0);
      check("midrst_queue_empty", exp_a.size(), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("midrst_no_resume", pulses_a - base, 2);
      send_a(8'h10);
      drain_a("drain_10");

      // Full FIFO with a push in the LOAD cycle, tx_busy driven by hand.
      manual_a = 1'b1; manual_busy_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rd_valid_a = 1'b1;
         rd_data_a  = 8'h11 + i[7:0];
         push_exp_a(8'h11 + i[7:0]);
         @(negedge clk);
      end
      rd_valid_a = 1'b0;
      @(negedge clk);
      check("full_fifo_count", fifo_count_a, 4);
      for (int k = 0; k < 4; k++) begin
         manual_busy_a = 1'b0;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!tx_start_a && n < 50);
         check("manual_start_seen", tx_start_a, 1);
         manual_busy_a = 1'b1;
         @(negedge clk);
      end
      manual_busy_a = 1'b0;
      @(negedge clk);
      // WAIT_LO -> LOAD has just happened; push while the head is popped.
      check("load_cycle_full", fifo_count_a, 4);
      rd_valid_a = 1'b1; rd_data_a = 8'h77;
      push_exp_a(8'h77);
      @(negedge clk);
      rd_valid_a = 1'b0;
      check("pushpop_fifo_count", fifo_count_a, 4);
      check("pushpop_no_overflow", overflow_a, 0);
      manual_a = 1'b0;
      drain_a("drain_77");
      check("final_overflow", overflow_a, 0);
      check("final_idle", idle_a, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
